// File: rtl/output_serializer.sv
// Block-to-word serializer: captures one DATA_WIDTH block over a valid/ready
// handshake and streams it out most-significant word first, flagging the last word.
module output_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  block_valid,
  input  logic [DATA_WIDTH-1:0] block_data,
  output logic                  block_ready,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_last,
  input  logic                  word_ready,
  output logic                  busy
);

  localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_index;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IDX_W-1:0]      w_index_nxt;
  logic                  w_is_last;

  assign w_is_last = (r_index == LAST_IDX);

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_index <= w_index_nxt;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path through
  // this block leaves a value unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_index_nxt = r_index;
    unique case (r_state)
      ST_IDLE: begin
        if (block_valid) begin
          w_state_nxt = ST_SEND;
          w_shift_nxt = block_data;
          w_index_nxt = '0;
        end
      end
      ST_SEND: begin
        if (word_ready) begin
          if (w_is_last) begin
            // Shift register is left as-is; the next capture overwrites it.
            w_state_nxt = ST_IDLE;
            w_index_nxt = '0;
          end else begin
            w_shift_nxt = r_shift << WORD_WIDTH;
            w_index_nxt = r_index + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only; word_ready/block_valid never reach them.
  assign block_ready = (r_state == ST_IDLE);
  assign word_valid  = (r_state == ST_SEND);
  assign busy        = (r_state == ST_SEND);
  assign word_last   = (r_state == ST_SEND) && w_is_last;
  assign word_data   = r_shift[DATA_WIDTH-1 -: WORD_WIDTH];

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: queue-based word model checked
// every cycle, plus directed scenarios with literal expected words.
module tb_output_serializer;

  localparam int DW = 128;
  localparam int WW = 32;
  localparam int NW = DW / WW;

  localparam logic [DW-1:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] BF = {DW{1'b1}};
  localparam logic [DW-1:0] B3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          block_valid = 1'b0;
  logic [DW-1:0] block_data = '0;
  logic          block_ready;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_last;
  logic          word_ready = 1'b0;
  logic          busy;

  int total = 0;
  int bad   = 0;

  output_serializer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .block_valid(block_valid),
    .block_data (block_data),
    .block_ready(block_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a block becomes NW pending words; the head is what must be shown.
  logic [WW-1:0] m_q[$];
  bit            m_zero = 1'b1;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_q.delete();
      m_zero = 1'b1;
    end else if (m_q.size() != 0) begin
      if (word_ready) void'(m_q.pop_front());
    end else if (block_valid) begin
      for (int i = 0; i < NW; i++) m_q.push_back(block_data[DW-1-WW*i -: WW]);
      m_zero = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("block_ready", DW'(block_ready), DW'(m_q.size() == 0));
    check("word_valid",  DW'(word_valid),  DW'(m_q.size() != 0));
    check("busy",        DW'(busy),        DW'(m_q.size() != 0));
    check("word_last",   DW'(word_last),   DW'(m_q.size() == 1));
    if (m_q.size() != 0) check("word_data", DW'(word_data), DW'(m_q[0]));
    else if (m_zero)     check("word_data_zero", DW'(word_data), '0);
  end

  // Observed transfers and captures, for literal sequence checks.
  logic [WW-1:0] xfer_log[$];
  int            cap_log[$];
  int            cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (n_rst && word_valid && word_ready) xfer_log.push_back(word_data);
    if (n_rst && block_valid && block_ready) cap_log.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!block_ready && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", DW'(block_ready), DW'(1'b1));
  endtask

  task automatic check_log(input string name, input logic [WW-1:0] exp[$]);
    check({name, "_count"}, DW'(xfer_log.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size() && i < xfer_log.size(); i++)
      check(name, DW'(xfer_log[i]), DW'(exp[i]));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, DW'(block_ready), DW'(1'b1));
    check({name, "_valid"}, DW'(word_valid),  DW'(1'b0));
    check({name, "_last"},  DW'(word_last),   DW'(1'b0));
    check({name, "_busy"},  DW'(busy),        DW'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] exp[$];

    // Reset state during and after reset.
    #3;
    check_idle_outputs("reset_during");
    check("reset_during_data", DW'(word_data), '0);
    #9 n_rst = 1'b1;
    tick();
    check_idle_outputs("reset_after");
    check("reset_after_data", DW'(word_data), '0);

    // Basic stream with word_ready held high.
    xfer_log.delete();
    word_ready  = 1'b1;
    block_valid = 1'b1;
    block_data  = B1;
    tick();
    block_valid = 1'b0;
    check("basic_w0", DW'(word_data), DW'(32'h00112233));
    check("basic_w0_last", DW'(word_last), DW'(1'b0));
    tick(); check("basic_w1", DW'(word_data), DW'(32'h44556677));
    tick(); check("basic_w2", DW'(word_data), DW'(32'h8899AABB));
    tick(); check("basic_w3", DW'(word_data), DW'(32'hCCDDEEFF));
    check("basic_w3_last", DW'(word_last), DW'(1'b1));
    tick();
    check_idle_outputs("basic_done");
    exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    check_log("basic_seq", exp);

    // Backpressure while word 1 is presented.
    xfer_log.delete();
    tick();
    block_valid = 1'b1;
    block_data  = B1;
    tick();
    block_valid = 1'b0;
    tick();
    word_ready = 1'b0;
    check("bp_w1", DW'(word_data), DW'(32'h44556677));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", DW'(word_data), DW'(32'h44556677));
      check("bp_hold_last", DW'(word_last), DW'(1'b0));
    end
    word_ready = 1'b1;
    wait_idle(20);
    check_log("bp_seq", exp);

    // Upstream block offered during SEND must wait for IDLE.
    xfer_log.delete();
    cap_log.delete();
    block_valid = 1'b1;
    block_data  = B1;
    tick();
    block_data = BF;
    for (int i = 0; i < 3; i++) begin
      check("blocked_ready", DW'(block_ready), DW'(1'b0));
      tick();
    end
    wait_idle(20);
    tick();
    block_valid = 1'b0;
    check("blocked_f_w0", DW'(word_data), DW'(32'hFFFFFFFF));
    wait_idle(20);
    exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    check_log("blocked_seq", exp);
    check("blocked_caps", DW'(cap_log.size()), DW'(2));
    if (cap_log.size() == 2) check("blocked_period", DW'(cap_log[1] - cap_log[0]), DW'(5));

    // Back-to-back blocks with valid held high.
    xfer_log.delete();
    cap_log.delete();
    tick();
    block_valid = 1'b1;
    block_data  = B1;
    tick();
    block_data = B3;
    repeat (5) tick();
    block_valid = 1'b0;
    wait_idle(20);
    exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
            32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    check_log("b2b_seq", exp);
    check("b2b_caps", DW'(cap_log.size()), DW'(2));
    if (cap_log.size() == 2) check("b2b_period", DW'(cap_log[1] - cap_log[0]), DW'(5));

    // Reset after word 1 transfers; remainder must vanish.
    xfer_log.delete();
    tick();
    block_valid = 1'b1;
    block_data  = B1;
    tick();
    block_valid = 1'b0;
    tick();
    tick();
    check("rstmid_w2_shown", DW'(word_data), DW'(32'h8899AABB));
    #2 n_rst = 1'b0;
    #1;
    check_idle_outputs("rstmid_now");
    check("rstmid_now_data", DW'(word_data), '0);
    tick();
    n_rst = 1'b1;
    tick();
    check_idle_outputs("rstmid_after");
    block_valid = 1'b1;
    block_data  = B3;
    tick();
    block_valid = 1'b0;
    check("rstmid_new_w0", DW'(word_data), DW'(32'hDEADBEEF));
    wait_idle(20);
    exp = '{32'h00112233, 32'h44556677,
            32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    check_log("rstmid_seq", exp);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
# output_serializer

Transmit-side counterpart to the 128-bit block register: accepts one 128-bit result block from the cipher datapath over a valid/ready handshake and streams it out as four 32-bit words over a second valid/ready handshake, most-significant word first. It sits between the cipher core's output and the narrow host/bus-side interface. It buffers exactly one block, tolerates arbitrary downstream backpressure, and flags the final word of each block.

## Interface
- DATA_WIDTH, 128, width of the input block
- WORD_WIDTH, 32, width of each output word; DATA_WIDTH must be an integer multiple of WORD_WIDTH (NUM_WORDS = DATA_WIDTH/WORD_WIDTH = 4 by default)
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  asynchronous, active-low reset
- block_valid  input  1  upstream has a block on block_data
- block_data  input  DATA_WIDTH  block to transmit; word 0 = bits [DATA_WIDTH-1 -: WORD_WIDTH]
- block_ready  output  1  serializer can capture a block this cycle
- word_valid  output  1  word_data holds a valid word
- word_data  output  WORD_WIDTH  current output word
- word_last  output  1  current word is the last word of its block
- word_ready  input  1  downstream accepts word_data this cycle
- busy  output  1  a block is held and not fully transmitted

## Operation
- State machine: IDLE, SEND.
- IDLE: block_ready = 1, word_valid = 0, busy = 0. On block_valid & block_ready at a rising edge: load block_data into shift register, clear word index to 0, go to SEND.
- SEND: block_ready = 0, word_valid = 1, busy = 1. word_data = top WORD_WIDTH bits of shift register. word_last = 1 iff word index == NUM_WORDS-1.
- Transfer occurs on a rising edge with word_valid & word_ready. On transfer of a non-last word: shift register shifts left by WORD_WIDTH (zero-fill), index increments. On transfer of the last word: go to IDLE, index to 0.
- word_valid & !word_ready: word_data, word_last, index and state hold unchanged (no drop, no duplicate).
- block_valid while in SEND is ignored (block_ready = 0); upstream must hold its block.
- No capture in the same cycle as the last-word transfer; the next block is captured at the earliest one cycle later (from IDLE).
- Index counter is log2(NUM_WORDS) bits; never wraps past NUM_WORDS-1 in SEND.

## Timing
- Reset (n_rst = 0, asynchronous, takes effect immediately): state IDLE, shift register 0, index 0. Outputs during and after reset: block_ready = 1, word_valid = 0, word_data = 0, word_last = 0, busy = 0.
- Reset mid-block: held block discarded; no further words emitted; block_ready = 1 once n_rst deasserted with no other action needed.
- Latency: capture at edge N -> word 0 on word_data with word_valid = 1 immediately after edge N.
- With word_ready held 1: words 0..3 presented in cycles following edges N, N+1, N+2, N+3; word_last during word 3; block_ready = 1 after edge N+4. Peak throughput: one block per NUM_WORDS+1 cycles.
- All outputs are derived from registered state only (no combinational path from word_ready or block_valid to any output).

## Test plan
- Reset: assert n_rst = 0 mid-cycle -> block_ready = 1, word_valid = 0, word_data = 0, word_last = 0, busy = 0 immediately and after release.
- Basic stream: capture 128'h00112233_44556677_8899AABB_CCDDEEFF with word_ready = 1 -> words 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF on four consecutive cycles, word_last only on 32'hCCDDEEFF, block_ready high the cycle after.
- Backpressure: same block, word_ready = 0 for 3 cycles while word 1 presented -> word_data holds 32'h44556677, word_last = 0, no word skipped or repeated; sequence completes when word_ready returns to 1.
- Blocked upstream: assert block_valid with 128'hFFFF...FFFF during SEND -> ignored, block_ready = 0, current block streams unaltered; captured only after return to IDLE, then streams 32'hFFFFFFFF x4.
- Back-to-back: block_valid held high with two blocks -> second capture exactly one cycle after first block's last-word transfer; 5-cycle period per block with word_ready = 1.
- Reset mid-block: n_rst pulsed low after word 1 transfers -> word_valid drops immediately, words 2-3 never appear; new block after release streams from its word 0.
